vid_stream_gen: RTL
===================

Name: vid_stream_gen

Overview:
- Synthesizable video-stream source. Drives the di/de/hs/vs pixel protocol consumed by scaler_h, scaler_v and monitor.
- Produces test patterns at configurable pixel sparsity, line gap and frame gap.
- Used for on-board bring-up of the scaler chain in place of a camera, and as a bench stimulus source.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- DE_PERIOD, 4: cycles per pixel. Pixel occupies P = max(DE_PERIOD,1) cycles, with de on the last. 0 and 1 both mean dense.
- LINE_GAP, 44: cycles of hs=1 between lines. Must be ≥1.
- FRAME_GAP, 14: extra cycles of vs=1 after the last line's gap. Must be ≥1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- en_i, input, 1: run request, level-sensitive.
- pattern_i, input, 2: 0 = x ramp, 1 = y ramp, 2 = checker, 3 = centre delta pulse.
- width_i, input, 16: pixels per line.
- height_i, input, 16: lines per frame.
- do_o, output, DATA_WIDTH: pixel data, valid when de_o=1.
- de_o, output, 1: pixel strobe.
- hs_o, output, 1: 1 = horizontal blanking, 0 = line active.
- vs_o, output, 1: 1 = vertical blanking, 0 = frame active.
- busy_o, output, 1: 1 whenever state ≠ IDLE.
- frame_done_o, output, 1: one-cycle pulse on the last cycle of VGAP.

Behaviour:
- All outputs are registered.
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=1, busy_o=0, frame_done_o=0. All counters cleared, state IDLE.
- Reset asserted mid-frame forces these values asynchronously. Generation restarts only after reset release plus en_i=1.
- FSM states: IDLE, LINE, HGAP, VGAP.
- IDLE:
  - Outputs hold hs=1, vs=1, de=0.
  - On a clk edge with en_i=1, width_i≠0 and height_i≠0: latch width, height and pattern, set x=0, y=0, phase=0, go to LINE.
  - First LINE cycle (hs_o=0, vs_o=0) appears on the edge after en_i is sampled.
  - Zero width or height keeps the block in IDLE.
- LINE:
  - hs_o=0, vs_o=0.
  - phase counts 0..P-1. de_o=1 only when phase=P-1; do_o carries pixel(x,y) in the same cycle.
  - At phase=P-1: x increments and phase wraps to 0.
  - At x=width-1 with phase=P-1: go to HGAP. Line length is exactly width*P cycles.
- HGAP:
  - hs_o=1, de_o=0, do_o holds its last value. Duration LINE_GAP cycles.
  - vs_o=1 if the line just finished was y=height-1, else 0.
  - At end of gap: if y<height-1, increment y, clear x, go to LINE. Otherwise go to VGAP.
- VGAP:
  - hs_o=1, vs_o=1. Duration FRAME_GAP cycles. frame_done_o=1 on the final cycle.
  - Then, if en_i=1: relatch width/height/pattern and go to LINE (y=0). Otherwise go to IDLE.
- Inputs are sampled only at frame start, so en_i falling or width/height/pattern changing mid-frame does not affect the current frame; it completes fully.
- Pixel function, result truncated to DATA_WIDTH LSBs:
  - 0 (x ramp): x.
  - 1 (y ramp): y.
  - 2 (checker): all ones if x[3]^y[3], else 0.
  - 3 (centre delta): all ones if x==width>>1 and y==height>>1, else 0.
- Counters are 16 bits and never wrap within a frame, because x<width and y<height always hold.
- Frame length in cycles is height*(width*P + LINE_GAP) + FRAME_GAP.

Test Plan:
- Dense ramp. DE_PERIOD=0, width=8, height=2, pattern 0, en_i held. Line 0 shows 8 consecutive de pulses with do_o=0..7 and hs_o=0, then 44 cycles hs=1/vs=0. Line 1 is identical with vs_o=1 during its gap. frame_done_o pulses after 14 VGAP cycles, then frame 2 starts immediately.
- Sparse timing. DE_PERIOD=4, width=5, height=3. Each line has de at cycles 3,7,11,15,19 after hs falls, so hs is low for exactly 20 cycles. Frame totals 3*(20+44)+14=206 cycles between successive frame starts.
- Delta pulse. width=25, height=25, pattern 3. Exactly one de beat has do_o=255, at x=12, y=12. All other 624 beats are 0.
- Stop mid-frame. Drop en_i during line 1 of 4. All 4 lines and VGAP complete, frame_done_o pulses once, then IDLE with hs=vs=1, busy_o=0.
- Async reset. Assert rst=0 mid-LINE between clock edges. Outputs go to de=0, hs=1, vs=1 without waiting for clk. After release with en_i=1, the next frame begins at x=0, y=0.
- Zero size. width_i=0, en_i=1 for 100 cycles: busy_o stays 0 and no de pulses occur.

Source files
------------

// File: rtl/vid_stream_gen.sv
// Video-stream source: emits di/de/hs/vs frames carrying a selectable test pattern
// with configurable pixel sparsity, line gap and frame gap. All outputs are registered.
module vid_stream_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DE_PERIOD  = 4,
    parameter int unsigned LINE_GAP   = 44,
    parameter int unsigned FRAME_GAP  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            pattern_i,
    input  logic [15:0]           width_i,
    input  logic [15:0]           height_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    // DE_PERIOD of 0 or 1 both mean one cycle per pixel
    localparam int unsigned P          = (DE_PERIOD > 1) ? DE_PERIOD : 1;
    localparam logic [15:0] PHASE_LAST = 16'(P - 1);
    localparam logic [15:0] LGAP_LAST  = 16'(LINE_GAP - 1);
    localparam logic [15:0] FGAP_LAST  = 16'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, LINE, HGAP, VGAP} state_t;

    state_t      state, state_nxt;
    logic [15:0] x, x_nxt, y, y_nxt, phase, phase_nxt, gap, gap_nxt;
    logic [15:0] width, width_nxt, height, height_nxt;
    logic [1:0]  pattern, pattern_nxt;
    logic        start_ok;
    logic        de_nxt, vs_nxt, frame_done_nxt;
    logic [DATA_WIDTH-1:0] pix;

    assign start_ok = en_i && (width_i != 16'd0) && (height_i != 16'd0);

    // Next-state: frame sequencing; geometry and pattern are latched only at frame start
    always_comb begin
        state_nxt   = state;
        x_nxt       = x;
        y_nxt       = y;
        phase_nxt   = phase;
        gap_nxt     = gap;
        width_nxt   = width;
        height_nxt  = height;
        pattern_nxt = pattern;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt   = LINE;
                    width_nxt   = width_i;
                    height_nxt  = height_i;
                    pattern_nxt = pattern_i;
                    x_nxt       = 16'd0;
                    y_nxt       = 16'd0;
                    phase_nxt   = 16'd0;
                end
            end
            LINE: begin
                if (phase == PHASE_LAST) begin
                    phase_nxt = 16'd0;
                    if (x == width - 16'd1) begin
                        state_nxt = HGAP;
                        gap_nxt   = 16'd0;
                    end else begin
                        x_nxt = x + 16'd1;
                    end
                end else begin
                    phase_nxt = phase + 16'd1;
                end
            end
            HGAP: begin
                if (gap == LGAP_LAST) begin
                    if (y != height - 16'd1) begin
                        state_nxt = LINE;
                        y_nxt     = y + 16'd1;
                        x_nxt     = 16'd0;
                        phase_nxt = 16'd0;
                    end else begin
                        state_nxt = VGAP;
                        gap_nxt   = 16'd0;
                    end
                end else begin
                    gap_nxt = gap + 16'd1;
                end
            end
            VGAP: begin
                if (gap == FGAP_LAST) begin
                    if (start_ok) begin
                        state_nxt   = LINE;
                        width_nxt   = width_i;
                        height_nxt  = height_i;
                        pattern_nxt = pattern_i;
                        x_nxt       = 16'd0;
                        y_nxt       = 16'd0;
                        phase_nxt   = 16'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        de_nxt         = (state_nxt == LINE) && (phase_nxt == PHASE_LAST);
        vs_nxt         = (state_nxt == IDLE) || (state_nxt == VGAP) ||
                         ((state_nxt == HGAP) && (y_nxt == height_nxt - 16'd1));
        frame_done_nxt = (state_nxt == VGAP) && (gap_nxt == FGAP_LAST);
        pix            = '0;
        unique case (pattern_nxt)
            2'd0: pix = DATA_WIDTH'(x_nxt);
            2'd1: pix = DATA_WIDTH'(y_nxt);
            2'd2: pix = (x_nxt[3] ^ y_nxt[3]) ? {DATA_WIDTH{1'b1}} : '0;
            2'd3: pix = ((x_nxt == (width_nxt >> 1)) && (y_nxt == (height_nxt >> 1))) ?
                        {DATA_WIDTH{1'b1}} : '0;
            default: pix = '0;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            phase        <= '0;
            gap          <= '0;
            width        <= '0;
            height       <= '0;
            pattern      <= '0;
            do_o         <= '0;
            de_o         <= 1'b0;
            hs_o         <= 1'b1;
            vs_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            phase        <= phase_nxt;
            gap          <= gap_nxt;
            width        <= width_nxt;
            height       <= height_nxt;
            pattern      <= pattern_nxt;
            if (de_nxt) do_o <= pix;
            de_o         <= de_nxt;
            hs_o         <= (state_nxt != LINE);
            vs_o         <= vs_nxt;
            busy_o       <= (state_nxt != IDLE);
            frame_done_o <= frame_done_nxt;
        end
    end

endmodule
